sobel_stream_engine: RTL and testbench

Parametrised, self-contained successor to the current edge-detection datapath. It merges line buffering, 3x3 window formation, Sobel gradient computation and output buffering into one streaming block. The block has a credit-based input ready, a configurable pixel width and image geometry, and end-of-line and end-of-frame events. It sits between the DMA input stream and the DMA output stream, and runs entirely in the AXI clock domain.

---
 rtl/sobel_stream_engine.sv | 182 ++++++++++++++++++
 tb/tb_sobel_stream_engine.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge engine: line buffers, window, gradients, magnitude, FWFT output FIFO.
// Optional binarisation of the magnitude against i_threshold when SOBEL_THRESH_EN is defined.
module sobel_stream_engine #(
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_ready,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_data_ready,
  input  logic [DATA_W-1:0] i_threshold,
  output logic              o_intr,
  output logic              o_frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int MW    = AW + 1;
  localparam int CW    = AW + 2;
  localparam int GW    = DATA_W + 4;
  localparam int NPOP  = (IMG_W - 2) * (IMG_H - 2);
  localparam int PW    = $clog2(NPOP + 1);

  typedef enum logic {FILL, ACTIVE} phase_t;

  phase_t              phase;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic                lb_sel;
  logic [DATA_W-1:0]   lb0 [IMG_W];
  logic [DATA_W-1:0]   lb1 [IMG_W];
  logic [DATA_W-1:0]   rd_row1, rd_row2;
  logic [DATA_W-1:0]   win [3][3];
  logic                v1, v2, v3;
  logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;
  logic [GW-1:0]       ax, ay, mag;
  logic [DATA_W-1:0]   res, mag_q;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [MW-1:0]       mem_cnt;
  logic [PW-1:0]       pop_cnt;
  logic                accept, col_last, row_last, pop, out_free, mem_rd, mem_wr;
  logic [CW-1:0]       occupancy;

  assign accept   = i_data_valid && o_data_ready;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));

  // lb_sel picks which RAM holds row-1; the other holds row-2 and takes the new pixel.
  assign rd_row1 = lb_sel ? lb1[col] : lb0[col];
  assign rd_row2 = lb_sel ? lb0[col] : lb1[col];

  always_ff @(posedge i_clk) begin
    if (accept) begin
      if (lb_sel) lb0[col] <= i_data;
      else        lb1[col] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col    <= '0;
      row    <= '0;
      phase  <= FILL;
      lb_sel <= 1'b0;
      o_intr <= 1'b0;
      v1     <= 1'b0;
    end else begin
      o_intr <= accept && col_last;
      v1     <= accept && (phase == ACTIVE) && (col >= COL_W'(2));
      if (accept) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= rd_row2;
        win[1][2] <= rd_row1;
        win[2][2] <= i_data;
        if (col_last) begin
          col    <= '0;
          lb_sel <= ~lb_sel;
          if (row_last) begin
            row   <= '0;
            phase <= FILL;
          end else begin
            row <= row + ROW_W'(1);
            if (row == ROW_W'(1)) phase <= ACTIVE;
          end
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  always_comb begin
    logic signed [GW-1:0] p [3][3];
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned c = 0; c < 3; c++)
        p[r][c] = $signed({4'b0000, win[r][c]});
    gx_c = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    gy_c = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
  end

  always_comb begin
    ax  = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    ay  = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    mag = ax + ay;
`ifdef SOBEL_THRESH_EN
    res = (mag > {4'b0000, i_threshold}) ? '1 : '0;
`else
    res = (mag[GW-1:DATA_W] != '0) ? '1 : mag[DATA_W-1:0];
`endif
  end

`ifndef SOBEL_THRESH_EN
  logic unused_threshold;
  assign unused_threshold = ^i_threshold;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v2 <= v1;
      v3 <= v2;
    end
    gx_q  <= gx_c;
    gy_q  <= gy_c;
    mag_q <= res;
  end

  // The output register is the FIFO head; an empty FIFO lets a push bypass memory.
  assign pop       = o_data_valid && i_data_ready;
  assign out_free  = !o_data_valid || pop;
  assign mem_rd    = out_free && (mem_cnt != '0);
  assign mem_wr    = v3 && !(out_free && (mem_cnt == '0));
  assign occupancy = CW'(mem_cnt) + CW'(o_data_valid) + CW'(v1) + CW'(v2) + CW'(v3);
  assign o_data_ready = (occupancy < CW'(FIFO_DEPTH));

  always_ff @(posedge i_clk) begin
    if (mem_wr) mem[wr_ptr] <= mag_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mem_cnt      <= '0;
      o_data_valid <= 1'b0;
      o_data       <= '0;
      pop_cnt      <= '0;
      o_frame_done <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
      if (mem_rd) rd_ptr <= rd_ptr + AW'(1);
      mem_cnt <= mem_cnt + MW'(mem_wr) - MW'(mem_rd);
      if (out_free) begin
        if (mem_rd) begin
          o_data       <= mem[rd_ptr];
          o_data_valid <= 1'b1;
        end else if (v3) begin
          o_data       <= mag_q;
          o_data_valid <= 1'b1;
        end else begin
          o_data_valid <= 1'b0;
        end
      end
      o_frame_done <= pop && (pop_cnt == PW'(NPOP - 1));
      if (pop) pop_cnt <= (pop_cnt == PW'(NPOP - 1)) ? '0 : pop_cnt + PW'(1);
    end
  end

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Scoreboard bench for sobel_stream_engine on a 5x4 frame with an 8-entry output FIFO.
module tb_sobel_stream_engine;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int D  = 8;
  localparam int MAXV = (1 << DW) - 1;

  logic          clk;
  logic          rst;
  logic          i_data_valid;
  logic [DW-1:0] i_data;
  logic          o_data_ready;
  logic          o_data_valid;
  logic [DW-1:0] o_data;
  logic          i_data_ready;
  logic [DW-1:0] thr;
  logic          o_intr;
  logic          o_frame_done;

  sobel_stream_engine #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .o_data_ready (o_data_ready),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .i_data_ready (i_data_ready),
    .i_threshold  (thr),
    .o_intr       (o_intr),
    .o_frame_done (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int got_q[$];
  int img[H][W];
  int m_col = 0, m_row = 0;
  int n_pops = 0, n_intr = 0, n_done = 0;
  int first_win_cyc = -1, first_valid_cyc = -1;
  logic prev_stall = 1'b0, prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int golden(int r, int c);
    int w[3][3];
    int gx, gy, m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = img[r-2+i][c-2+j];
    gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
    gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
    return (m > int'(thr)) ? MAXV : 0;
`else
    return (m > MAXV) ? MAXV : m;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_col = 0;
      m_row = 0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (o_intr) n_intr++;
      if (o_frame_done) n_done++;
      if (o_data_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) chk("hold", o_data, prev_data);
      if (o_data_valid && i_data_ready) begin
        n_pops++;
        got_q.push_back(int'(o_data));
        if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
        else chk("pixel", o_data, exp_q.pop_front());
      end
      if (i_data_valid && o_data_ready) begin
        img[m_row][m_col] = int'(i_data);
        if (m_row >= 2 && m_col >= 2) begin
          exp_q.push_back(golden(m_row, m_col));
          if (first_win_cyc < 0) first_win_cyc = cyc;
        end
        if (m_col == W-1) begin
          m_col = 0;
          m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
      prev_stall = o_data_valid && !i_data_ready;
      prev_data  = o_data;
      prev_valid = o_data_valid;
    end
  end

  task automatic send_px(input int p);
    int g;
    i_data = DW'(p);
    i_data_valid = 1'b1;
    @(negedge clk);
    g = 0;
    while (!o_data_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // kind 0: flat lvl, 1: vertical step 0|lvl at col 2, 2: random
  task automatic send_frame(input int kind, input int lvl);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_px(kind == 0 ? lvl : kind == 1 ? (c < 2 ? 0 : lvl) : int'($urandom_range(0, MAXV)));
    i_data_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("drained", exp_q.size(), 0);
    chk("idle_valid", o_data_valid, 0);
  endtask

  task automatic check_step(input string tag, input int hi);
    int v;
    for (int i = 0; i < 6; i++) begin
      v = (i < got_q.size()) ? got_q[i] : -1;
      chk(tag, v, (i % 3 == 2) ? 0 : hi);
    end
  endtask

  initial begin
    int p0, d0, i0, k, g;
    logic stalled;
    int pix[40];

    rst = 1'b1;
    i_data_valid = 1'b0;
    i_data = '0;
    i_data_ready = 1'b1;
    thr = DW'(30);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_data_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_intr", o_intr, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_ready", o_data_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // flat frame plus first-output latency from an empty FIFO
    p0 = n_pops; d0 = n_done; i0 = n_intr;
    first_win_cyc = -1; first_valid_cyc = -1;
    send_frame(0, 77);
    drain();
    chk("flat_pops", n_pops - p0, 6);
    chk("flat_intr", n_intr - i0, 4);
    chk("flat_done", n_done - d0, 1);
    chk("latency", first_valid_cyc - first_win_cyc, 4);

    got_q.delete();
    p0 = n_pops; d0 = n_done;
    send_frame(1, 100);
    drain();
    chk("step100_pops", n_pops - p0, 6);
    chk("step100_done", n_done - d0, 1);
    check_step("step100", MAXV);

    got_q.delete();
    send_frame(1, 10);
    drain();
`ifdef SOBEL_THRESH_EN
    check_step("step10", MAXV);
`else
    check_step("step10", 40);
`endif

    // backpressure: two frames back to back with the sink stalled
    for (int i = 0; i < 40; i++) pix[i] = int'($urandom_range(0, MAXV));
    i_data_ready = 1'b0;
    p0 = n_pops; d0 = n_done;
    k = 0;
    stalled = 1'b0;
    while (k < 40 && !stalled) begin
      i_data = DW'(pix[k]);
      i_data_valid = 1'b1;
      @(negedge clk);
      if (o_data_ready) begin
        @(posedge clk);
        #1;
        k++;
      end else begin
        stalled = 1'b1;
      end
    end
    chk("ready_drop", stalled, 1);
    chk("credit_at_drop", exp_q.size(), D);
    repeat (20) @(negedge clk);
    chk("ready_held_low", o_data_ready, 0);
    chk("bp_valid", o_data_valid, 1);
    @(posedge clk);
    #1;
    i_data_valid = 1'b0;
    i_data_ready = 1'b1;
    g = 0;
    @(posedge clk);
    #1;
    while (o_data_valid && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("bp_buffered", n_pops - p0, D);
    while (k < 40) begin
      send_px(pix[k]);
      k++;
    end
    i_data_valid = 1'b0;
    drain();
    chk("bp_pops", n_pops - p0, 12);
    chk("bp_done", n_done - d0, 2);

    // reset at row 2, col 3 with one window in flight
    for (int i = 0; i < 13; i++) send_px(int'($urandom_range(0, MAXV)));
    i_data_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", o_data_valid, 0);
    chk("midrst_ready", o_data_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_quiet", o_data_valid, 0);
    p0 = n_pops; d0 = n_done;
    send_frame(2, 0);
    drain();
    chk("midrst_pops", n_pops - p0, 6);
    chk("midrst_done", n_done - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
